// File: rtl/window3x3_gen.sv
// window3x3_gen: raster-to-window front end.
// Buffers the two previous lines in on-chip line memories and emits a registered
// 3x3 RGB neighbourhood centred one row up and one column left of the pixel just
// accepted, together with the centre coordinates. Border centres are never emitted.
module window3x3_gen #(
    parameter int IMG_W = 640,  // active pixels per line (>= 3)
    parameter int IMG_H = 480,  // active lines per frame (>= 3)
    parameter int XW    = 10,   // column counter width, 2**XW >= IMG_W
    parameter int YW    = 10    // row counter width, 2**YW >= IMG_H
) (
    input  logic          iCLK,
    input  logic          iRST,
    input  logic          iSOF,
    input  logic          iDVAL,
    input  logic [7:0]    iRed,
    input  logic [7:0]    iGreen,
    input  logic [7:0]    iBlue,
    output logic [23:0]   oW0,
    output logic [23:0]   oW1,
    output logic [23:0]   oW2,
    output logic [23:0]   oW3,
    output logic [23:0]   oW4,
    output logic [23:0]   oW5,
    output logic [23:0]   oW6,
    output logic [23:0]   oW7,
    output logic [23:0]   oW8,
    output logic          oDVAL,
    output logic [XW-1:0] oX,
    output logic [YW-1:0] oY
);

    localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);
    localparam logic [XW-1:0] X_MIN  = XW'(2);
    localparam logic [YW-1:0] Y_MIN  = YW'(2);

    // Raster position of the next pixel to be accepted.
    logic [XW-1:0] col_q, col_d;
    logic [YW-1:0] row_q, row_d;

    // Position of the pixel presented this cycle (start of frame forces the origin).
    logic [XW-1:0] pos_x;
    logic [YW-1:0] pos_y;

    logic          accept;
    logic          win_valid;
    logic [23:0]   pix_in;

    // Line memories: lb0 holds row y-1, lb1 holds row y-2, both indexed by column.
    logic [23:0]   lb0_mem [IMG_W];
    logic [23:0]   lb1_mem [IMG_W];
    logic [23:0]   lb0_rd;
    logic [23:0]   lb1_rd;

    // Column shift registers per window row; index 2 is the newest (rightmost) column.
    logic [23:0]   top_q [3];
    logic [23:0]   mid_q [3];
    logic [23:0]   bot_q [3];

    assign pix_in = {iRed, iGreen, iBlue};
    assign accept = iDVAL && !iRST;
    assign pos_x  = iSOF ? '0 : col_q;
    assign pos_y  = iSOF ? '0 : row_q;

    // Asynchronous read at the current column: the value seen here is the one stored
    // before this cycle's write, which gives read-before-write ordering for free.
    assign lb0_rd = lb0_mem[pos_x];
    assign lb1_rd = lb1_mem[pos_x];

    // Interior centres only: the window needs two buffered rows and two shifted columns.
    assign win_valid = accept && (pos_x >= X_MIN) && (pos_y >= Y_MIN);

    // Next raster position: advance on accept, wrap at line end and frame end.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no
        // path leaves it unassigned, which would otherwise infer a latch.
        col_d = col_q;
        row_d = row_q;
        if (iDVAL) begin
            if (pos_x == X_LAST) begin
                col_d = '0;
                row_d = (pos_y == Y_LAST) ? '0 : pos_y + YW'(1);
            end else begin
                col_d = pos_x + XW'(1);
                row_d = pos_y;
            end
        end else if (iSOF) begin
            col_d = '0;
            row_d = '0;
        end
    end

    // Position counter registers.
    always_ff @(posedge iCLK) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples the pre-edge values, independent of statement order.
        if (iRST) begin
            col_q <= '0;
            row_q <= '0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
        end
    end

    // Line memory update: push the column down one line and store the new pixel.
    always_ff @(posedge iCLK) begin
        // NOTE: the line memories are deliberately not reset; stale contents are
        // never emitted because windows wait until two fresh rows are buffered.
        if (accept) begin
            lb1_mem[pos_x] <= lb0_mem[pos_x];
            lb0_mem[pos_x] <= pix_in;
        end
    end

    // Column shift: the three rows of the newest column enter on the right.
    always_ff @(posedge iCLK) begin
        if (accept) begin
            top_q[0] <= top_q[1];
            top_q[1] <= top_q[2];
            top_q[2] <= lb1_rd;
            mid_q[0] <= mid_q[1];
            mid_q[1] <= mid_q[2];
            mid_q[2] <= lb0_rd;
            bot_q[0] <= bot_q[1];
            bot_q[1] <= bot_q[2];
            bot_q[2] <= pix_in;
        end
    end

    // Registered window output: loaded with the post-shift columns on interior accepts,
    // held otherwise, with a one-cycle valid pulse.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            oDVAL <= 1'b0;
            oX    <= '0;
            oY    <= '0;
            oW0   <= '0;
            oW1   <= '0;
            oW2   <= '0;
            oW3   <= '0;
            oW4   <= '0;
            oW5   <= '0;
            oW6   <= '0;
            oW7   <= '0;
            oW8   <= '0;
        end else begin
            oDVAL <= win_valid;
            if (win_valid) begin
                oX  <= pos_x - XW'(1);
                oY  <= pos_y - YW'(1);
                oW0 <= top_q[1];
                oW1 <= top_q[2];
                oW2 <= lb1_rd;
                oW3 <= mid_q[1];
                oW4 <= mid_q[2];
                oW5 <= lb0_rd;
                oW6 <= bot_q[1];
                oW7 <= bot_q[2];
                oW8 <= pix_in;
            end
        end
    end

endmodule

// File: tb/tb_window3x3_gen.sv
// tb_window3x3_gen: directed/random bench for window3x3_gen.
// An 8x6 instance and a 3x3 instance share the stimulus; a frame-image model
// predicts every window from the stored pixels of the current frame.
module tb_window3x3_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        sof;
    logic        dval;
    logic [7:0]  red, green, blue;

    logic [23:0] b_w0, b_w1, b_w2, b_w3, b_w4, b_w5, b_w6, b_w7, b_w8;
    logic        b_dval;
    logic [2:0]  b_x, b_y;
    logic [23:0] s_w0, s_w1, s_w2, s_w3, s_w4, s_w5, s_w6, s_w7, s_w8;
    logic        s_dval;
    logic [1:0]  s_x, s_y;

    always #5 clk = ~clk;

    window3x3_gen #(.IMG_W(8), .IMG_H(6), .XW(3), .YW(3)) dut (
        .iCLK(clk), .iRST(rst), .iSOF(sof), .iDVAL(dval),
        .iRed(red), .iGreen(green), .iBlue(blue),
        .oW0(b_w0), .oW1(b_w1), .oW2(b_w2), .oW3(b_w3), .oW4(b_w4),
        .oW5(b_w5), .oW6(b_w6), .oW7(b_w7), .oW8(b_w8),
        .oDVAL(b_dval), .oX(b_x), .oY(b_y)
    );

    window3x3_gen #(.IMG_W(3), .IMG_H(3), .XW(2), .YW(2)) dut_s (
        .iCLK(clk), .iRST(rst), .iSOF(sof), .iDVAL(dval),
        .iRed(red), .iGreen(green), .iBlue(blue),
        .oW0(s_w0), .oW1(s_w1), .oW2(s_w2), .oW3(s_w3), .oW4(s_w4),
        .oW5(s_w5), .oW6(s_w6), .oW7(s_w7), .oW8(s_w8),
        .oDVAL(s_dval), .oX(s_x), .oY(s_y)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Model state: geometry, next raster position, current frame image, held outputs.
    bit          sel = 1'b0;  // 0: check the 8x6 instance, 1: the 3x3 instance
    int          cw = 8, ch = 6;
    int          mx = 0, my = 0;
    logic [23:0] img [0:5][0:7];
    bit          exp_v;
    int          exp_x, exp_y;
    logic [215:0] exp_w;
    int          win_cnt = 0;
    logic [247:0] win_log [$];
    logic [247:0] ref_log [$];

    task automatic check(input string tag, input logic [215:0] obs, input logic [215:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [215:0] obs_w();
        return sel ? {s_w0, s_w1, s_w2, s_w3, s_w4, s_w5, s_w6, s_w7, s_w8}
                   : {b_w0, b_w1, b_w2, b_w3, b_w4, b_w5, b_w6, b_w7, b_w8};
    endfunction

    function automatic logic obs_v();
        return sel ? s_dval : b_dval;
    endfunction

    function automatic logic [15:0] obs_x();
        return sel ? 16'(s_x) : 16'(b_x);
    endfunction

    function automatic logic [15:0] obs_y();
        return sel ? 16'(s_y) : 16'(b_y);
    endfunction

    function automatic logic [23:0] pat(input int x, input int y);
        logic [7:0] rv;
        rv = 8'(y * 16 + x);
        return {rv, 8'hA5, 8'h5A};
    endfunction

    // Compare all outputs with the model's expectation and log any window seen.
    task automatic compare_all(input string tag);
        check({tag, "_dval"}, 216'(obs_v()), 216'(exp_v));
        check({tag, "_x"}, 216'(obs_x()), 216'(exp_x));
        check({tag, "_y"}, 216'(obs_y()), 216'(exp_y));
        check({tag, "_win"}, obs_w(), exp_w);
        if (obs_v() === 1'b1) begin
            win_cnt++;
            win_log.push_back({obs_x(), obs_y(), obs_w()});
        end
    endtask

    // One clock of stimulus; the model predicts the outputs seen after the edge.
    task automatic step(input bit s, input bit v, input logic [23:0] pix);
        int x, y;
        sof  = s;
        dval = v;
        {red, green, blue} = pix;
        exp_v = 1'b0;
        if (v) begin
            x = s ? 0 : mx;
            y = s ? 0 : my;
            img[y][x] = pix;
            if (x >= 2 && y >= 2) begin
                exp_v = 1'b1;
                exp_x = x - 1;
                exp_y = y - 1;
                exp_w = {img[y-2][x-2], img[y-2][x-1], img[y-2][x],
                         img[y-1][x-2], img[y-1][x-1], img[y-1][x],
                         img[y][x-2],   img[y][x-1],   img[y][x]};
            end
            x++;
            if (x == cw) begin
                x = 0;
                y++;
                if (y == ch) y = 0;
            end
            mx = x;
            my = y;
        end else if (s) begin
            mx = 0;
            my = 0;
        end
        @(posedge clk);
        #1;
        compare_all("step");
    endtask

    // Reset for n cycles with live-looking inputs, which reset must override.
    task automatic do_reset(input int n);
        rst = 1'b1;
        exp_v = 1'b0;
        exp_x = 0;
        exp_y = 0;
        exp_w = '0;
        mx = 0;
        my = 0;
        for (int i = 0; i < n; i++) begin
            dval = 1'b1;
            sof  = 1'($urandom_range(0, 1));
            {red, green, blue} = 24'($urandom);
            @(posedge clk);
            #1;
            compare_all("reset");
        end
        rst  = 1'b0;
        dval = 1'b0;
        sof  = 1'b0;
    endtask

    function automatic logic [23:0] rnd_pix();
        return 24'($urandom);
    endfunction

    initial begin
        logic [215:0] raster;
        logic [23:0]  p;
        int           base;

        rst = 1'b1;
        sof = 1'b0;
        dval = 1'b0;
        {red, green, blue} = '0;
        @(posedge clk);
        #1;

        // Reset held 3 cycles: all outputs zero.
        do_reset(3);

        // Frame 1: continuous pattern with directed corner checks.
        win_cnt = 0;
        win_log.delete();
        for (int y = 0; y < 6; y++) begin
            for (int x = 0; x < 8; x++) begin
                step(1'b0, 1'b1, pat(x, y));
                if (x == 2 && y == 2) begin
                    check("first_dval", 216'(b_dval), 216'(1));
                    check("first_x", 216'(b_x), 216'(1));
                    check("first_y", 216'(b_y), 216'(1));
                    check("first_w0r", 216'(b_w0[23:16]), 216'(8'h00));
                    check("first_w4r", 216'(b_w4[23:16]), 216'(8'h11));
                    check("first_w8r", 216'(b_w8[23:16]), 216'(8'h22));
                end
                if (x == 7 && y == 5) begin
                    check("last_x", 216'(b_x), 216'(6));
                    check("last_y", 216'(b_y), 216'(4));
                    check("last_w4r", 216'(b_w4[23:16]), 216'(8'h46));
                    check("last_w8r", 216'(b_w8[23:16]), 216'(8'h57));
                end
            end
        end
        check("frame1_count", 216'(win_cnt), 216'(24));
        ref_log = win_log;

        // Frame 2: auto-restart, same pattern with ~40% idle cycles.
        win_cnt = 0;
        win_log.delete();
        for (int y = 0; y < 6; y++) begin
            for (int x = 0; x < 8; x++) begin
                while ($urandom_range(0, 99) < 40) step(1'b0, 1'b0, rnd_pix());
                step(1'b0, 1'b1, pat(x, y));
                if (x == 1 && y == 2) check("restart_nowin", 216'(win_cnt), 216'(0));
            end
        end
        check("gap_count", 216'(win_cnt), 216'(24));
        for (int i = 0; i < 24; i++) begin
            if (i < win_log.size()) check("gap_seq", win_log[i], ref_log[i]);
        end

        // Frame 3: iSOF with a pixel at (4,3) restarts the frame with new data.
        for (int i = 0; i < 3 * 8 + 4; i++) step(1'b0, 1'b1, pat(i % 8, i / 8));
        win_cnt = 0;
        win_log.delete();
        step(1'b1, 1'b1, rnd_pix());
        for (int i = 1; i < 48; i++) step(1'b0, 1'b1, rnd_pix());
        check("sof_count", 216'(win_cnt), 216'(24));
        if (win_log.size() > 0) begin
            check("sof_first_x", 216'(win_log[0][247:232]), 216'(1));
            check("sof_first_y", 216'(win_log[0][231:216]), 216'(1));
        end

        // Frame 4: reset one cycle after pixel (5,4), then a fresh frame without iSOF.
        for (int i = 0; i < 4 * 8 + 6; i++) step(1'b0, 1'b1, pat(i % 8, i / 8));
        do_reset(1);
        win_cnt = 0;
        for (int i = 0; i < 48; i++) begin
            if ($urandom_range(0, 99) < 25) step(1'b0, 1'b0, rnd_pix());
            step(1'b0, 1'b1, rnd_pix());
        end
        check("rst_count", 216'(win_cnt), 216'(24));

        // Minimum size: the single window equals the nine pixels in raster order.
        sel = 1'b1;
        cw = 3;
        ch = 3;
        do_reset(2);
        for (int f = 0; f < 2; f++) begin
            win_cnt = 0;
            raster = '0;
            for (int i = 0; i < 9; i++) begin
                p = rnd_pix();
                base = (8 - i) * 24;
                raster[base +: 24] = p;
                step(1'b0, 1'b1, p);
            end
            check("min_count", 216'(win_cnt), 216'(1));
            check("min_x", 216'(s_x), 216'(1));
            check("min_y", 216'(s_y), 216'(1));
            check("min_win", {s_w0, s_w1, s_w2, s_w3, s_w4, s_w5, s_w6, s_w7, s_w8}, raster);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
